// File: rtl/matmul_sequencer_if.sv
// Handshake and memory-strobe bundle between the matmul sequencer and the
// surrounding datapath (MEM_A, MEM_B, MAC lanes, MEM_C).
interface matmul_sequencer_if #(
  parameter int A_W = 10,
  parameter int B_W = 8,
  parameter int C_W = 10
);
  logic           start;
  logic           busy;
  logic           done;
  logic [A_W-1:0] a_addr;
  logic [B_W-1:0] b_addr;
  logic           ab_nce;
  logic           acc_en;
  logic           acc_first;
  logic [C_W-1:0] c_addr;
  logic [1:0]     c_sel;
  logic           c_nwrt;
  logic           c_nce;

  // Sequencer side.
  modport master (
    input  start,
    output busy, done, a_addr, b_addr, ab_nce, acc_en, acc_first,
           c_addr, c_sel, c_nwrt, c_nce
  );

  // Controller / datapath side.
  modport slave (
    output start,
    input  busy, done, a_addr, b_addr, ab_nce, acc_en, acc_first,
           c_addr, c_sel, c_nwrt, c_nce
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Start/done sequencer for the int8 matrix-multiply engine. For every
// (row i, column group jg) it streams KDIM reads from MEM_A/MEM_B, lets the
// read latency drain while the MAC lanes finish accumulating, then writes the
// four lane results to MEM_C. All outputs come straight from flops.
module matmul_sequencer #(
  parameter int ROWS    = 32,
  parameter int KDIM    = 32,
  parameter int COLG    = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  matmul_sequencer_if.master  bus
);

  localparam int IW  = (ROWS > 1)    ? $clog2(ROWS)    : 1;
  localparam int KW  = (KDIM > 1)    ? $clog2(KDIM)    : 1;
  localparam int GW  = (COLG > 1)    ? $clog2(COLG)    : 1;
  localparam int DW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int A_W = $clog2(ROWS * KDIM);
  localparam int B_W = $clog2(KDIM * COLG);
  localparam int C_W = $clog2(ROWS * COLG * 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_i;
  logic [GW-1:0]    r_jg;
  logic [KW-1:0]    r_k;
  logic [DW-1:0]    r_d;
  logic [1:0]       r_w;

  logic             r_busy;
  logic             r_done;
  logic             r_ab_nce;
  logic [A_W-1:0]   r_a_addr;
  logic [B_W-1:0]   r_b_addr;
  logic [C_W-1:0]   r_c_addr;
  logic [1:0]       r_c_sel;
  logic             r_c_nwrt;

  logic [MEM_LAT-1:0] r_vld_p;
  logic [MEM_LAT-1:0] r_first_p;

  logic             w_vld_p0;
  logic             w_first_p0;

  function automatic logic [A_W-1:0] f_a_addr(input logic [IW-1:0] i,
                                              input logic [KW-1:0] k);
    return A_W'(int'(i) * KDIM + int'(k));
  endfunction

  function automatic logic [B_W-1:0] f_b_addr(input logic [KW-1:0] k,
                                              input logic [GW-1:0] jg);
    return B_W'(int'(k) * COLG + int'(jg));
  endfunction

  function automatic logic [C_W-1:0] f_c_addr(input logic [IW-1:0] i,
                                              input logic [GW-1:0] jg,
                                              input logic [1:0]    w);
    return C_W'(int'(i) * (COLG * 4) + int'(jg) * 4 + int'(w));
  endfunction

  // A read is in flight this cycle; first beat of a group when k is zero.
  assign w_vld_p0   = ~r_ab_nce;
  assign w_first_p0 = ~r_ab_nce & (r_k == '0);

  // Main sequencer: loop counters, state and registered memory strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_jg     <= '0;
      r_k      <= '0;
      r_d      <= '0;
      r_w      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ab_nce <= 1'b1;
      r_a_addr <= '0;
      r_b_addr <= '0;
      r_c_addr <= '0;
      r_c_sel  <= '0;
      r_c_nwrt <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state  <= S_FETCH;
            r_i      <= '0;
            r_jg     <= '0;
            r_k      <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_ab_nce <= 1'b0;
            r_a_addr <= '0;
            r_b_addr <= '0;
          end
        end
        S_FETCH: begin
          if (r_k == KW'(KDIM - 1)) begin
            r_state  <= S_DRAIN;
            r_k      <= '0;
            r_d      <= '0;
            r_ab_nce <= 1'b1;
          end else begin
            r_k      <= r_k + KW'(1);
            r_a_addr <= f_a_addr(r_i, r_k + KW'(1));
            r_b_addr <= f_b_addr(r_k + KW'(1), r_jg);
          end
        end
        S_DRAIN: begin
          // Wait out the memory latency so the last product is accumulated
          // before the lanes are read out.
          if (r_d == DW'(MEM_LAT - 1)) begin
            r_state  <= S_WRITE;
            r_d      <= '0;
            r_w      <= '0;
            r_c_nwrt <= 1'b0;
            r_c_sel  <= '0;
            r_c_addr <= f_c_addr(r_i, r_jg, 2'd0);
          end else begin
            r_d <= r_d + DW'(1);
          end
        end
        S_WRITE: begin
          if (r_w == 2'd3) begin
            r_w      <= '0;
            r_c_nwrt <= 1'b1;
            if (r_jg != GW'(COLG - 1)) begin
              r_state  <= S_FETCH;
              r_jg     <= r_jg + GW'(1);
              r_k      <= '0;
              r_ab_nce <= 1'b0;
              r_a_addr <= f_a_addr(r_i, '0);
              r_b_addr <= f_b_addr('0, r_jg + GW'(1));
            end else if (r_i != IW'(ROWS - 1)) begin
              r_state  <= S_FETCH;
              r_jg     <= '0;
              r_i      <= r_i + IW'(1);
              r_k      <= '0;
              r_ab_nce <= 1'b0;
              r_a_addr <= f_a_addr(r_i + IW'(1), '0);
              r_b_addr <= f_b_addr('0, '0);
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_w      <= r_w + 2'd1;
            r_c_sel  <= r_w + 2'd1;
            r_c_addr <= f_c_addr(r_i, r_jg, r_w + 2'd1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Delay the read-valid and first-beat flags by the memory read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p   <= '0;
      r_first_p <= '0;
    end else begin
      r_vld_p[0]   <= w_vld_p0;
      r_first_p[0] <= w_first_p0;
      for (int n = 1; n < MEM_LAT; n++) begin
        r_vld_p[n]   <= r_vld_p[n-1];
        r_first_p[n] <= r_first_p[n-1];
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.a_addr    = r_a_addr;
  assign bus.b_addr    = r_b_addr;
  assign bus.ab_nce    = r_ab_nce;
  assign bus.acc_en    = r_vld_p[MEM_LAT-1];
  assign bus.acc_first = r_first_p[MEM_LAT-1];
  assign bus.c_addr    = r_c_addr;
  assign bus.c_sel     = r_c_sel;
  assign bus.c_nwrt    = r_c_nwrt;
  assign bus.c_nce     = r_c_nwrt;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: one instance at MEM_LAT=1 and one at MEM_LAT=3,
// both compared cycle by cycle against an arithmetic model of the schedule.
module tb_matmul_sequencer;

  localparam int ROWS = 32;
  localparam int KDIM = 32;
  localparam int COLG = 8;

  // {busy, done, ab_nce, a_addr, b_addr, acc_en, acc_first, c_nwrt, c_nce, c_addr, c_sel}
  localparam logic [36:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 10'd0, 8'd0,
                                       1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 2'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;

  matmul_sequencer_if #(.A_W(10), .B_W(8), .C_W(10)) if0 ();
  matmul_sequencer_if #(.A_W(10), .B_W(8), .C_W(10)) if1 ();

  assign if0.start = start0;
  assign if1.start = start1;

  matmul_sequencer #(.ROWS(ROWS), .KDIM(KDIM), .COLG(COLG), .MEM_LAT(1)) u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (if0)
  );

  matmul_sequencer #(.ROWS(ROWS), .KDIM(KDIM), .COLG(COLG), .MEM_LAT(3)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1)
  );

  logic [36:0] obs0, obs1;
  assign obs0 = {if0.busy, if0.done, if0.ab_nce, if0.a_addr, if0.b_addr, if0.acc_en,
                 if0.acc_first, if0.c_nwrt, if0.c_nce, if0.c_addr, if0.c_sel};
  assign obs1 = {if1.busy, if1.done, if1.ab_nce, if1.a_addr, if1.b_addr, if1.acc_en,
                 if1.acc_first, if1.c_nwrt, if1.c_nce, if1.c_addr, if1.c_sel};

  int checks   = 0;
  int failures = 0;
  int wcount [1024];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int run_len(input int d);
    return ROWS * COLG * (KDIM + lat_of(d) + 4);
  endfunction

  function automatic logic [36:0] get_obs(input int d);
    return (d == 0) ? obs0 : obs1;
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 0) start0 = v; else start1 = v;
  endtask

  task automatic set_rst(input int d, input logic v);
    if (d == 0) rst0 = v; else rst1 = v;
  endtask

  // Expected outputs in cycle n (n=1 is the first FETCH cycle of a run).
  // Address fields are only meaningful while their strobe is active.
  function automatic logic [36:0] f_expect(input int lat, input int n,
                                           output logic [36:0] m);
    int L, run, g, t, i, jg, w;
    logic busy, done, nce, acc, first, nw, ma, mc;
    logic [9:0] a, c;
    logic [7:0] b;
    logic [1:0] sel;
    L = KDIM + lat + 4;
    run = ROWS * COLG * L;
    busy = 1'b0; done = 1'b0; nce = 1'b1; acc = 1'b0; first = 1'b0; nw = 1'b1;
    a = '0; b = '0; c = '0; sel = '0; ma = 1'b0; mc = 1'b0;
    if (n > run) begin
      done = 1'b1;
    end else begin
      g = (n - 1) / L;
      t = (n - 1) % L;
      i = g / COLG;
      jg = g % COLG;
      busy = 1'b1;
      if (t < KDIM) begin
        nce = 1'b0;
        a = 10'(i * KDIM + t);
        b = 8'(t * COLG + jg);
        ma = 1'b1;
      end
      if (t >= lat && t < KDIM + lat) begin
        acc = 1'b1;
        first = (t == lat);
      end
      if (t >= KDIM + lat) begin
        w = t - KDIM - lat;
        nw = 1'b0;
        c = 10'(i * COLG * 4 + jg * 4 + w);
        sel = 2'(w);
        mc = 1'b1;
      end
    end
    m = {3'b111, {10{ma}}, {8{ma}}, 4'hF, {10{mc}}, {2{mc}}};
    return {busy, done, nce, a, b, acc, first, nw, nw, c, sel};
  endfunction

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b1; start1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks += 2;
      if (obs0 !== RESET_VEC) begin
        failures++;
        $display("FAIL reset_lat1 cyc%0d: got %h expected %h", c, obs0, RESET_VEC);
      end
      if (obs1 !== RESET_VEC) begin
        failures++;
        $display("FAIL reset_lat3 cyc%0d: got %h expected %h", c, obs1, RESET_VEC);
      end
    end
    rst0 = 1'b0; rst1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks += 2;
      if (obs0 !== RESET_VEC) begin
        failures++;
        $display("FAIL idle_lat1 cyc%0d: got %h expected %h", c, obs0, RESET_VEC);
      end
      if (obs1 !== RESET_VEC) begin
        failures++;
        $display("FAIL idle_lat3 cyc%0d: got %h expected %h", c, obs1, RESET_VEC);
      end
    end
  endtask

  // Complete run from IDLE; mode 1 toggles start randomly while busy.
  task automatic test_full_run(input int d, input int mode);
    int run, lat, writes, bad, done_at;
    logic [36:0] e, m, o;
    run = run_len(d);
    lat = lat_of(d);
    writes = 0; bad = 0; done_at = 0;
    foreach (wcount[a]) wcount[a] = 0;
    set_start(d, 1'b1);
    for (int n = 1; n <= run + 3; n++) begin
      @(negedge clk);
      o = get_obs(d);
      e = f_expect(lat, n, m);
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL run_lat%0d cycle %0d: got %h expected %h mask %h", lat, n, o, e, m);
      end
      if (o[13] === 1'b0) begin
        writes++;
        wcount[o[11:2]]++;
      end
      if (o[35] === 1'b1 && done_at == 0) done_at = n;
      set_start(d, (mode == 1 && n < run) ? ($urandom_range(0, 1) != 0) : 1'b0);
    end
    checks++;
    if (done_at != run + 1) begin
      failures++;
      $display("FAIL done_cycle_lat%0d: got %0d expected %0d", lat, done_at, run + 1);
    end
    checks++;
    if (writes != ROWS * COLG * 4) begin
      failures++;
      $display("FAIL write_count_lat%0d: got %0d expected %0d", lat, writes, ROWS * COLG * 4);
    end
    foreach (wcount[a]) if (wcount[a] != 1) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL write_once_lat%0d: %0d addresses not written exactly once, expected 0", lat, bad);
    end
  endtask

  // From DONE, start held high restarts immediately and is ignored while busy.
  task automatic test_restart_held(input int d);
    int lat, ncyc;
    logic [36:0] e, m, o;
    lat = lat_of(d);
    ncyc = 2 * (KDIM + lat + 4) + 4;
    set_start(d, 1'b1);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      o = get_obs(d);
      e = f_expect(lat, n, m);
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL restart_lat%0d cycle %0d: got %h expected %h mask %h", lat, n, o, e, m);
      end
    end
    set_start(d, 1'b0);
    set_rst(d, 1'b1);
    @(negedge clk);
    o = get_obs(d);
    checks++;
    if (o !== RESET_VEC) begin
      failures++;
      $display("FAIL restart_rst_lat%0d: got %h expected %h", lat, o, RESET_VEC);
    end
    set_rst(d, 1'b0);
  endtask

  // Reset asserted during cycle n_rst of the first group, then a fresh start.
  task automatic test_rst_mid_op(input int d, input int n_rst);
    int lat;
    logic [36:0] e, m, o;
    lat = lat_of(d);
    set_start(d, 1'b1);
    for (int n = 1; n <= n_rst; n++) begin
      @(negedge clk);
      o = get_obs(d);
      e = f_expect(lat, n, m);
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL pre_rst_lat%0d cycle %0d: got %h expected %h mask %h", lat, n, o, e, m);
      end
      set_start(d, 1'b0);
    end
    set_rst(d, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      o = get_obs(d);
      checks++;
      if (o !== RESET_VEC) begin
        failures++;
        $display("FAIL rst_at%0d_lat%0d cyc%0d: got %h expected %h", n_rst, lat, c, o, RESET_VEC);
      end
      set_rst(d, 1'b0);
    end
    set_start(d, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      o = get_obs(d);
      e = f_expect(lat, n, m);
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL post_rst_lat%0d cycle %0d: got %h expected %h mask %h", lat, n, o, e, m);
      end
      set_start(d, 1'b0);
    end
    set_rst(d, 1'b1);
    @(negedge clk);
    set_rst(d, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_run(0, 1);
    test_restart_held(0);
    test_rst_mid_op(0, KDIM + 1 + 2);
    test_rst_mid_op(0, int'($urandom_range(1, KDIM + 1)));
    test_full_run(1, 0);
    test_restart_held(1);
    test_rst_mid_op(1, KDIM + 3 + 2);
    test_rst_mid_op(1, int'($urandom_range(KDIM - 2, KDIM + 3)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
